mips_cpu_bus_lsu: RTL

Parametrised load/store unit that sits between the multicycle MIPS core and the Avalon memory-mapped master port. It converts a single core memory request into one Avalon transfer, and holds that transfer stable across `waitrequest` stalls. It generates byte lanes and write-data replication for all MIPS-I widths, and returns sign/zero-extended or LWL/LWR-merged load data. It also adds alignment checking and a bus timeout, which the word-only bus path it replaces did not have.

---
 rtl/mips_cpu_bus_lsu.sv | 258 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mips_cpu_bus_lsu.sv
// mips_cpu_bus_lsu: load/store unit between the multicycle MIPS core and an Avalon-MM master.
// Each accepted core request becomes one Avalon transfer. The transfer is held stable across
// waitrequest stalls and is aborted after TIMEOUT stalled cycles (0 disables the timeout).
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   req_valid/req_ready         core request handshake (ready only while idle)
//   req_op/addr/wdata/rt        operation code, byte address, store data, old rt value
//   resp_valid/resp_data        one-cycle completion pulse with load result
//   err_align/err_timeout       error qualifiers for resp_valid
//   address/read/write/waitrequest/writedata/byteenable/readdata   Avalon master port
module mips_cpu_bus_lsu #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [31:0]       req_rt,
    output logic              resp_valid,
    output logic [31:0]       resp_data,
    output logic              err_align,
    output logic              err_timeout,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    output logic              write,
    input  logic              waitrequest,
    output logic [31:0]       writedata,
    output logic [3:0]        byteenable,
    input  logic [31:0]       readdata
);

    localparam logic [3:0] OpLw  = 4'd0;
    localparam logic [3:0] OpLb  = 4'd1;
    localparam logic [3:0] OpLbu = 4'd2;
    localparam logic [3:0] OpLh  = 4'd3;
    localparam logic [3:0] OpLhu = 4'd4;
    localparam logic [3:0] OpLwl = 4'd5;
    localparam logic [3:0] OpLwr = 4'd6;
    localparam logic [3:0] OpSw  = 4'd8;
    localparam logic [3:0] OpSb  = 4'd9;
    localparam logic [3:0] OpSh  = 4'd10;

    // The counter only has to reach TIMEOUT-1: the stall on that cycle is the TIMEOUT-th one.
    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rt_q, rt_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              ready_q, ready_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ealign_q, ealign_d;
    logic              etime_q, etime_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic [31:0]       wd_q, wd_d;
    logic [3:0]        be_q, be_d;

    // Request decode
    logic [1:0]  req_off;
    logic        req_legal;
    logic [3:0]  req_be;
    logic [31:0] req_wd;

    assign req_off = req_addr[1:0];

    always_comb begin
        req_legal = 1'b1;
        req_be    = 4'b0000;
        req_wd    = 32'h0;
        case (req_op)
            OpLw: begin
                req_legal = (req_off == 2'd0);
                req_be    = 4'b1111;
            end
            OpLb, OpLbu: req_be = 4'b0001 << req_off;
            OpLh, OpLhu: begin
                req_legal = ~req_off[0];
                req_be    = req_off[1] ? 4'b1100 : 4'b0011;
            end
            OpLwl: req_be = 4'b1111 >> (2'd3 - req_off);
            OpLwr: req_be = 4'b1111 << req_off;
            OpSw: begin
                req_legal = (req_off == 2'd0);
                req_be    = 4'b1111;
                req_wd    = req_wdata;
            end
            OpSb: begin
                req_be = 4'b0001 << req_off;
                req_wd = {4{req_wdata[7:0]}};
            end
            OpSh: begin
                req_legal = ~req_off[0];
                req_be    = req_off[1] ? 4'b1100 : 4'b0011;
                req_wd    = {2{req_wdata[15:0]}};
            end
            default: req_legal = 1'b0;
        endcase
    end

    // Load result formatting from the live readdata at the completing edge
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;

    assign rd_byte = readdata[{off_q, 3'b000} +: 8];
    assign rd_half = off_q[1] ? readdata[31:16] : readdata[15:0];

    always_comb begin
        load_data = 32'h0;
        case (op_q)
            OpLw:  load_data = readdata;
            OpLb:  load_data = {{24{rd_byte[7]}}, rd_byte};
            OpLbu: load_data = {24'h0, rd_byte};
            OpLh:  load_data = {{16{rd_half[15]}}, rd_half};
            OpLhu: load_data = {16'h0, rd_half};
            OpLwl: begin
                case (off_q)
                    2'd0:    load_data = {readdata[7:0], rt_q[23:0]};
                    2'd1:    load_data = {readdata[15:0], rt_q[15:0]};
                    2'd2:    load_data = {readdata[23:0], rt_q[7:0]};
                    default: load_data = readdata;
                endcase
            end
            OpLwr: begin
                case (off_q)
                    2'd0:    load_data = readdata;
                    2'd1:    load_data = {rt_q[31:24], readdata[31:8]};
                    2'd2:    load_data = {rt_q[31:16], readdata[31:16]};
                    default: load_data = {rt_q[31:8], readdata[31:24]};
                endcase
            end
            default: load_data = 32'h0;
        endcase
    end

    // Next-state logic; response fields default to 0 so they are only non-zero in RESP
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        off_d    = off_q;
        rt_d     = rt_q;
        cnt_d    = cnt_q;
        ready_d  = ready_q;
        addr_d   = addr_q;
        read_d   = read_q;
        write_d  = write_q;
        wd_d     = wd_q;
        be_d     = be_q;
        rvalid_d = 1'b0;
        rdata_d  = 32'h0;
        ealign_d = 1'b0;
        etime_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d    = req_op;
                    off_d   = req_off;
                    rt_d    = req_rt;
                    addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    be_d    = req_be;
                    wd_d    = req_wd;
                    ready_d = 1'b0;
                    if (req_legal) begin
                        state_d = StBus;
                        read_d  = ~req_op[3];
                        write_d = req_op[3];
                    end else begin
                        state_d  = StResp;
                        rvalid_d = 1'b1;
                        ealign_d = 1'b1;
                    end
                end
            end
            StBus: begin
                if (!waitrequest) begin
                    state_d  = StResp;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    cnt_d    = '0;
                    rvalid_d = 1'b1;
                    rdata_d  = op_q[3] ? 32'h0 : load_data;
                end else if ((TIMEOUT != 0) && (cnt_q == CntLast)) begin
                    state_d  = StResp;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    cnt_d    = '0;
                    rvalid_d = 1'b1;
                    etime_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= 4'h0;
            off_q    <= 2'd0;
            rt_q     <= 32'h0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'h0;
            ealign_q <= 1'b0;
            etime_q  <= 1'b0;
            addr_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            wd_q     <= 32'h0;
            be_q     <= 4'h0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            off_q    <= off_d;
            rt_q     <= rt_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            ealign_q <= ealign_d;
            etime_q  <= etime_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            write_q  <= write_d;
            wd_q     <= wd_d;
            be_q     <= be_d;
        end
    end

    assign req_ready   = ready_q;
    assign resp_valid  = rvalid_q;
    assign resp_data   = rdata_q;
    assign err_align   = ealign_q;
    assign err_timeout = etime_q;
    assign address     = addr_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = wd_q;
    assign byteenable  = be_q;

endmodule
